// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Covers the fetch FSM encoding, the reset PC and the canonical NOP.
package ifu_fetch_pkg;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam int          INST_W       = 32;
  localparam int          ADDR_W       = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch/stall event counters for the instruction fetch unit.
// Only present when IFU_PERF_CNT_EN is defined; both counters wrap at 2^64.
`ifdef IFU_PERF_CNT_EN
module ifu_perf_cnt
  import ifu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [63:0] fetch_cnt,
  output logic [63:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 64'd1;
      if (stall_inc) stall_cnt <= stall_cnt + 64'd1;
    end
  end

endmodule
`endif

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time and
// hands {inst, pc} to decode. Optional counters via IFU_PERF_CNT_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid_i_ifu,
  input  logic [63:0] redirect_pc_i_ifu,
  output logic        imem_req_o_ifu,
  output logic [63:0] imem_addr_o_ifu,
  input  logic        imem_ready_i_ifu,
  input  logic        imem_rvalid_i_ifu,
  input  logic [31:0] imem_rdata_i_ifu,
  output logic        inst_valid_o_ifu,
  output logic [31:0] inst_o_ifu,
  output logic [63:0] pc_o_ifu,
  input  logic        inst_ready_i_ifu
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0] fetch_cnt_o_ifu,
  output logic [63:0] stall_cnt_o_ifu
`endif
);

  ifu_state_e  state_q, state_d;
  logic        kill_q, kill_d;
  logic [63:0] pc_q, pc_d;
  logic        vld_p1, vld_d;
  logic [31:0] inst_p1, inst_d;
  logic [63:0] pc_p1, pc_p1_d;
  logic        req_fire;
  logic        hs;
  logic [63:0] redirect_pc_al;
  logic        unused_rdr_lsb;

  assign redirect_pc_al  = {redirect_pc_i_ifu[63:2], 2'b00};
  assign unused_rdr_lsb  = ^redirect_pc_i_ifu[1:0];
  assign imem_req_o_ifu  = (state_q == IFU_REQ);
  assign imem_addr_o_ifu = pc_q;
  assign req_fire        = imem_req_o_ifu & imem_ready_i_ifu;
  assign hs              = vld_p1 & inst_ready_i_ifu;

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    vld_d   = vld_p1;
    inst_d  = inst_p1;
    pc_p1_d = pc_p1;
    case (state_q)
      IFU_REQ: begin
        // A stale response left over from before reset is absorbed here.
        if (imem_rvalid_i_ifu) kill_d = 1'b0;
        if (req_fire) begin
          state_d = IFU_WAIT;
          if (redirect_valid_i_ifu) kill_d = 1'b1;
        end
      end
      IFU_WAIT: begin
        if (imem_rvalid_i_ifu) begin
          if (kill_q || redirect_valid_i_ifu) begin
            kill_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            vld_d   = 1'b1;
            inst_d  = imem_rdata_i_ifu;
            pc_p1_d = pc_q;
            pc_d    = pc_q + 64'(PC_STEP);
            state_d = IFU_HOLD;
          end
        end else if (redirect_valid_i_ifu) begin
          kill_d = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (hs || redirect_valid_i_ifu) begin
          vld_d   = 1'b0;
          state_d = IFU_REQ;
        end
      end
      default: state_d = IFU_REQ;
    endcase
    if (redirect_valid_i_ifu) pc_d = redirect_pc_al;
  end

  // Stage p1: registered output slot towards decode
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= IFU_REQ;
      pc_q    <= RESET_PC;
      // An in-flight request's response must not be taken after reset.
      kill_q  <= ((state_q == IFU_WAIT) | kill_q) & ~imem_rvalid_i_ifu;
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
      pc_p1   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_d;
      vld_p1  <= vld_d;
      inst_p1 <= inst_d;
      pc_p1   <= pc_p1_d;
    end
  end

  assign inst_valid_o_ifu = vld_p1;
  assign inst_o_ifu       = inst_p1;
  assign pc_o_ifu         = pc_p1;

`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (hs),
    .stall_inc ((state_q == IFU_WAIT) | ((state_q == IFU_HOLD) & ~inst_ready_i_ifu)),
    .fetch_cnt (fetch_cnt_o_ifu),
    .stall_cnt (stall_cnt_o_ifu)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level model of the fetch stream plus an
// in-order memory with random latency; directed scenarios then random traffic.
`timescale 1ns/1ps
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_ready;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk                  (clk),
    .rst                  (rst),
    .redirect_valid_i_ifu (redirect_valid),
    .redirect_pc_i_ifu    (redirect_pc),
    .imem_req_o_ifu       (imem_req),
    .imem_addr_o_ifu      (imem_addr),
    .imem_ready_i_ifu     (imem_ready),
    .imem_rvalid_i_ifu    (imem_rvalid),
    .imem_rdata_i_ifu     (imem_rdata),
    .inst_valid_o_ifu     (inst_valid),
    .inst_o_ifu           (inst),
    .pc_o_ifu             (pc),
    .inst_ready_i_ifu     (inst_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt_o_ifu      (fetch_cnt),
    .stall_cnt_o_ifu      (stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Model state: next PC the unit must request/present, and the slot expectation.
  logic [63:0] exp_pc;
  bit          slot_live;
  bit          must_drop;
  logic [63:0] slot_pc, last_pc;
  logic [31:0] slot_inst, last_inst;
  int          hs_total;
  logic [63:0] m_fcnt, m_scnt;

  // In-order memory: queued request addresses and the cycle their response is due.
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  int          cyc      = 0;
  int          last_due = -1;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = INST_NOP;

  // Per-cycle trace since the last reset release, for hand-computed expectations.
  logic        h_req[64];
  logic [63:0] h_addr[64];
  logic        h_valid[64];
  logic [63:0] h_pc[64];
  logic [31:0] h_inst[64];
  int          hidx;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (fixed_en) return fixed_data;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mem_resp(output logic rv, output logic [31:0] rd);
    rv = 1'b0;
    rd = $urandom;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      rv = 1'b1;
      rd = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
  endtask

  task automatic do_reset(input int n);
    logic rv;
    logic [31:0] rd;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_resp(rv, rd);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_ready     = 1'b0;
      inst_ready     = 1'b0;
      imem_rvalid    = rv;
      imem_rdata     = rd;
      cyc++;
    end
    exp_pc    = RESET_PC_DEF;
    slot_live = 1'b0;
    must_drop = 1'b0;
    last_pc   = '0;
    last_inst = '0;
    m_fcnt    = '0;
    m_scnt    = '0;
    hidx      = 0;
  endtask

  task automatic step(input bit rdr, input logic [63:0] rpc, input bit irdy,
                      input bit mrdy, input int lat);
    logic rv;
    logic [31:0] rd;
    int due;
    @(negedge clk);
    if (hidx < 64) begin
      h_req[hidx]   = imem_req;
      h_addr[hidx]  = imem_addr;
      h_valid[hidx] = inst_valid;
      h_pc[hidx]    = pc;
      h_inst[hidx]  = inst;
      hidx++;
    end
    // Compare the visible outputs against the model.
    if (must_drop) begin
      chk("valid_drop", inst_valid, 1'b0);
      must_drop = 1'b0;
      slot_live = 1'b0;
    end else if (slot_live) begin
      chk("slot_valid", inst_valid, 1'b1);
      chk("slot_pc", pc, slot_pc);
      chk("slot_inst", inst, slot_inst);
    end else if (inst_valid === 1'b1) begin
      chk("new_pc", pc, exp_pc);
      chk("new_inst", inst, mem_word(exp_pc));
      slot_live = 1'b1;
      slot_pc   = pc;
      slot_inst = inst;
      last_pc   = pc;
      last_inst = inst;
    end
    if (inst_valid !== 1'b1 && !slot_live) begin
      chk("hold_pc", pc, last_pc);
      chk("hold_inst", inst, last_inst);
    end
    if (imem_req === 1'b1) chk("req_addr", imem_addr, exp_pc);
    if (inst_valid === 1'b1) chk("req_in_hold", imem_req, 1'b0);
`ifdef IFU_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fcnt);
    chk("stall_cnt", stall_cnt, m_scnt);
`endif
    // Drive the inputs for the coming edge.
    mem_resp(rv, rd);
    rst            = 1'b0;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    inst_ready     = irdy;
    imem_ready     = mrdy;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    // Advance the model across that edge.
    if (imem_req === 1'b1 && mrdy) begin
      due = cyc + 1 + lat;
      if (due <= last_due) due = last_due + 1;
      mq_addr.push_back(imem_addr);
      mq_due.push_back(due);
      last_due = due;
    end
    if ((imem_req !== 1'b1 && inst_valid !== 1'b1) || (inst_valid === 1'b1 && !irdy))
      m_scnt = m_scnt + 64'd1;
    if (inst_valid === 1'b1 && irdy) begin
      hs_total++;
      m_fcnt    = m_fcnt + 64'd1;
      exp_pc    = exp_pc + 64'd4;
      must_drop = 1'b1;
    end
    if (rdr) begin
      exp_pc = {rpc[63:2], 2'b00};
      if (inst_valid === 1'b1) must_drop = 1'b1;
    end
    cyc++;
  endtask

  initial begin
    int hs_start;
    logic [63:0] rpc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    hs_total = 0;

    // Basic fetch with zero-wait memory and an always-ready decoder.
    fixed_en = 1'b1; fixed_data = 32'h0000_0093;
    do_reset(2);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
    chk("rst_valid", h_valid[0], 1'b0);
    chk("rst_pc", h_pc[0], 64'h0);
    chk("rst_inst", h_inst[0], 32'h0);
    chk("t1_req0", h_req[0], 1'b1);
    chk("t1_addr0", h_addr[0], 64'h8000_0000);
    chk("t1_valid1", h_valid[1], 1'b0);
    chk("t1_valid2", h_valid[2], 1'b1);
    chk("t1_pc2", h_pc[2], 64'h8000_0000);
    chk("t1_inst2", h_inst[2], 32'h0000_0093);
    chk("t1_req3", h_req[3], 1'b1);
    chk("t1_addr3", h_addr[3], 64'h8000_0004);
    fixed_en = 1'b0;

    // Decoder back-pressure for five cycles while an instruction is held.
    do_reset(2);
    step(1'b0, '0, 1'b1, 1'b1, 0);
    step(1'b0, '0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, 0);
    step(1'b0, '0, 1'b1, 1'b1, 0);
    step(1'b0, '0, 1'b1, 1'b0, 0);
    for (int i = 2; i < 8; i++) begin
      chk("t2_valid", h_valid[i], 1'b1);
      chk("t2_pc", h_pc[i], 64'h8000_0000);
      chk("t2_noreq", h_req[i], 1'b0);
    end
    chk("t2_req8", h_req[8], 1'b1);
    chk("t2_addr8", h_addr[8], 64'h8000_0004);

    // Redirect while waiting; the late response must be discarded.
    do_reset(2);
    step(1'b0, '0, 1'b1, 1'b1, 2);
    step(1'b1, 64'h8000_1002, 1'b1, 1'b1, 0);
    step(1'b0, '0, 1'b1, 1'b1, 0);
    step(1'b0, '0, 1'b1, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) chk("t3_novalid", h_valid[i], 1'b0);
    chk("t3_waiting", h_req[2], 1'b0);
    chk("t3_req4", h_req[4], 1'b1);
    chk("t3_addr4", h_addr[4], 64'h8000_1000);

    // Redirect in the same cycle as the response.
    do_reset(2);
    step(1'b0, '0, 1'b1, 1'b1, 0);
    step(1'b1, 64'h8000_2000, 1'b1, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1'b0, 0);
    chk("t4_valid2", h_valid[2], 1'b0);
    chk("t4_req2", h_req[2], 1'b1);
    chk("t4_addr2", h_addr[2], 64'h8000_2000);
    chk("t4_valid3", h_valid[3], 1'b0);

    // Reset while a request is outstanding; its stale response follows release.
    do_reset(2);
    step(1'b1, 64'h8000_3000, 1'b1, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1'b1, 3);
    do_reset(2);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
    chk("t5_req0", h_req[0], 1'b1);
    chk("t5_addr0", h_addr[0], 64'h8000_0000);
    for (int i = 0; i < 4; i++) chk("t5_stale", h_valid[i], 1'b0);
    chk("t5_valid4", h_valid[4], 1'b1);
    chk("t5_pc4", h_pc[4], 64'h8000_0000);

    // PC increment wraps past the top of the address space.
    do_reset(2);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
    chk("t6_pc3", h_pc[3], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_addr4", h_addr[4], 64'h0);

`ifdef IFU_PERF_CNT_EN
    // Ten fetches, decoder stalls two cycles on each.
    do_reset(2);
    for (int f = 0; f < 10; f++) begin
      step(1'b0, '0, 1'b1, 1'b1, 0);
      step(1'b0, '0, 1'b1, 1'b1, 0);
      step(1'b0, '0, 1'b0, 1'b1, 0);
      step(1'b0, '0, 1'b0, 1'b1, 0);
      step(1'b0, '0, 1'b1, 1'b1, 0);
    end
    step(1'b0, '0, 1'b1, 1'b0, 0);
    chk("t7_fetch_cnt", fetch_cnt, 64'd10);
    chk("t7_stall_cnt", stall_cnt, 64'd30);
`endif

    // Random traffic: redirects, back-pressure and variable memory latency.
    do_reset(2);
    hs_start = hs_total;
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 7))
        0:       rpc = {62'h3FFF_FFFF_FFFF_FFFF, 2'($urandom)};
        1, 2:    rpc = {$urandom, $urandom};
        default: rpc = {32'h0, $urandom};
      endcase
      step(($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 7), $urandom_range(0, 3));
    end
    checks++;
    if (hs_total - hs_start < 100) begin
      failures++;
      $display("FAIL rand_progress actual=%0d required>=100", hs_total - hs_start);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
